instruction_decode_stage: RTL and testbench

INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

---
 rtl/instruction_decode_stage.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_instruction_decode_stage.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: RV32I decode with a small output FIFO.
// Ports:
//   clk, reset_n            single clock, async active-low reset
//   in_valid/in_ready       intake handshake; in_word/in_pc are the raw word and its PC
//   flush                   empties the FIFO and returns to RUN
//   out_valid/out_ready     head handshake; out_instr/out_pc/out_mem_* describe the head
//   out_illegal             head was an illegal word and is carried as I_NOP
//   state                   RUN=0, HALTED=1 (after EBREAK), TRAPPED=2 (after illegal)
//   illegal_count           saturating count of illegal words accepted
// Only in_word[31:0] is decoded; XLEN must be at least 32.
package instruction_decode_pkg;
    typedef enum logic [5:0] {
        I_NOP, I_LUI, I_AUIPC, I_JAL, I_JALR,
        I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
        I_LOAD, I_STORE,
        I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI,
        I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND,
        I_EBREAK
    } op_e;

    // Register fields are zero where the format has no such field.
    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } Instruction;
endpackage

module instruction_decode_stage
    import instruction_decode_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned DEPTH           = 2,
    parameter bit          SUBWORD_MEM     = 1'b1,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_word,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output Instruction       out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [1:0]       out_mem_size,
    output logic             out_mem_unsigned,
    output logic             out_illegal,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] illegal_count
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StRun = 2'd0, StHalted = 2'd1, StTrapped = 2'd2} st_e;

    typedef struct packed {
        Instruction      instr;
        logic [XLEN-1:0] pc;
        logic [1:0]      mem_size;
        logic            mem_unsigned;
        logic            illegal;
    } entry_t;

    // ---------------- combinational decode ----------------
    logic [31:0] w;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    Instruction  dec_instr;
    logic [1:0]  dec_size;
    logic        dec_unsigned, dec_illegal, dec_ebreak;

    assign w      = in_word[31:0];
    assign opcode = w[6:0];
    assign funct3 = w[14:12];
    assign funct7 = w[31:25];
    assign imm_i  = {{20{w[31]}}, w[31:20]};
    assign imm_s  = {{20{w[31]}}, w[31:25], w[11:7]};
    assign imm_b  = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    assign imm_u  = {w[31:12], 12'b0};
    assign imm_j  = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};

    always_comb begin
        dec_instr    = '0;
        dec_size     = 2'd2;
        dec_unsigned = 1'b0;
        dec_illegal  = 1'b0;
        dec_ebreak   = 1'b0;
        case (opcode)
            7'b0110111: begin
                dec_instr.op  = I_LUI;
                dec_instr.rd  = w[11:7];
                dec_instr.imm = imm_u;
            end
            7'b0010111: begin
                dec_instr.op  = I_AUIPC;
                dec_instr.rd  = w[11:7];
                dec_instr.imm = imm_u;
            end
            7'b1101111: begin
                dec_instr.op  = I_JAL;
                dec_instr.rd  = w[11:7];
                dec_instr.imm = imm_j;
            end
            7'b1100111: begin
                dec_instr.op  = I_JALR;
                dec_instr.rd  = w[11:7];
                dec_instr.rs1 = w[19:15];
                dec_instr.imm = imm_i;
                dec_illegal   = (funct3 != 3'b000);
            end
            7'b1100011: begin
                dec_instr.rs1 = w[19:15];
                dec_instr.rs2 = w[24:20];
                dec_instr.imm = imm_b;
                case (funct3)
                    3'b000:  dec_instr.op = I_BEQ;
                    3'b001:  dec_instr.op = I_BNE;
                    3'b100:  dec_instr.op = I_BLT;
                    3'b101:  dec_instr.op = I_BGE;
                    3'b110:  dec_instr.op = I_BLTU;
                    3'b111:  dec_instr.op = I_BGEU;
                    default: dec_illegal  = 1'b1;
                endcase
            end
            7'b0000011: begin
                dec_instr.op  = I_LOAD;
                dec_instr.rd  = w[11:7];
                dec_instr.rs1 = w[19:15];
                dec_instr.imm = imm_i;
                dec_size      = funct3[1:0];
                dec_unsigned  = funct3[2];
                dec_illegal   = SUBWORD_MEM ? (funct3 == 3'b011 || funct3[2:1] == 2'b11)
                                            : (funct3 != 3'b010);
            end
            7'b0100011: begin
                dec_instr.op  = I_STORE;
                dec_instr.rs1 = w[19:15];
                dec_instr.rs2 = w[24:20];
                dec_instr.imm = imm_s;
                dec_size      = funct3[1:0];
                dec_illegal   = SUBWORD_MEM ? (funct3[2] || funct3[1:0] == 2'b11)
                                            : (funct3 != 3'b010);
            end
            7'b0010011: begin
                dec_instr.rd  = w[11:7];
                dec_instr.rs1 = w[19:15];
                dec_instr.imm = imm_i;
                case (funct3)
                    3'b000: dec_instr.op = I_ADDI;
                    3'b010: dec_instr.op = I_SLTI;
                    3'b011: dec_instr.op = I_SLTIU;
                    3'b100: dec_instr.op = I_XORI;
                    3'b110: dec_instr.op = I_ORI;
                    3'b111: dec_instr.op = I_ANDI;
                    3'b001: begin
                        dec_instr.op  = I_SLLI;
                        dec_instr.imm = {27'b0, w[24:20]};
                        dec_illegal   = (funct7 != 7'b0000000);
                    end
                    default: begin
                        dec_instr.op  = (funct7 == 7'b0100000) ? I_SRAI : I_SRLI;
                        dec_instr.imm = {27'b0, w[24:20]};
                        dec_illegal   = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                endcase
            end
            7'b0110011: begin
                dec_instr.rd  = w[11:7];
                dec_instr.rs1 = w[19:15];
                dec_instr.rs2 = w[24:20];
                case ({funct7, funct3})
                    10'b0000000_000: dec_instr.op = I_ADD;
                    10'b0100000_000: dec_instr.op = I_SUB;
                    10'b0000000_001: dec_instr.op = I_SLL;
                    10'b0000000_010: dec_instr.op = I_SLT;
                    10'b0000000_011: dec_instr.op = I_SLTU;
                    10'b0000000_100: dec_instr.op = I_XOR;
                    10'b0000000_101: dec_instr.op = I_SRL;
                    10'b0100000_101: dec_instr.op = I_SRA;
                    10'b0000000_110: dec_instr.op = I_OR;
                    10'b0000000_111: dec_instr.op = I_AND;
                    default:         dec_illegal  = 1'b1;
                endcase
            end
            7'b0001111: dec_illegal = (funct3 != 3'b000);  // FENCE is a legal NOP
            7'b1110011: begin
                dec_ebreak   = (w == 32'h0010_0073);
                dec_illegal  = !dec_ebreak;
                dec_instr.op = dec_ebreak ? I_EBREAK : I_NOP;
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal words travel as a clean NOP with word-sized, signed memory attributes.
        if (dec_illegal) begin
            dec_instr    = '0;
            dec_size     = 2'd2;
            dec_unsigned = 1'b0;
        end
    end

    // ---------------- FIFO and control ----------------
    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    st_e               state_q, state_d;
    logic [CNT_W-1:0]  ill_cnt_q, ill_cnt_d;
    logic              push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(DEPTH - 1)) return '0;
        return p + PtrW'(1);
    endfunction

    assign in_ready  = (state_q == StRun) && (count_q < CntW'(DEPTH)) && !flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        state_d   = state_q;
        ill_cnt_d = ill_cnt_q;
        if (flush) begin
            // push is impossible here because in_ready is low during flush
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            state_d  = StRun;
        end else begin
            if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push) begin
                mem_d[wr_ptr_q] = '{instr: dec_instr, pc: in_pc, mem_size: dec_size,
                                    mem_unsigned: dec_unsigned, illegal: dec_illegal};
                wr_ptr_d = ptr_inc(wr_ptr_q);
                if (dec_ebreak) begin
                    state_d = StHalted;
                end else if (dec_illegal && TRAP_ON_ILLEGAL) begin
                    state_d = StTrapped;
                end
            end
            if (push && !pop) count_d = count_q + CntW'(1);
            if (pop && !push) count_d = count_q - CntW'(1);
        end
        if (push && dec_illegal && (ill_cnt_q != '1)) ill_cnt_d = ill_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= StRun;
            ill_cnt_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    // Payload storage needs no reset: it is only observed while out_valid is high.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_instr        = mem_q[rd_ptr_q].instr;
    assign out_pc           = mem_q[rd_ptr_q].pc;
    assign out_mem_size     = mem_q[rd_ptr_q].mem_size;
    assign out_mem_unsigned = mem_q[rd_ptr_q].mem_unsigned;
    assign out_illegal      = out_valid && mem_q[rd_ptr_q].illegal;
    assign state            = state_q;
    assign illegal_count    = ill_cnt_q;
endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: two instances share stimulus.
//   A: defaults (DEPTH=2, SUBWORD_MEM=1, TRAP_ON_ILLEGAL=1, CNT_W=8)
//   B: DEPTH=3, SUBWORD_MEM=0, TRAP_ON_ILLEGAL=0, CNT_W=2 (saturates quickly)
// A queue-based model per instance is checked every falling edge, plus literal checks.
`timescale 1ns/1ps
module tb_instruction_decode_stage;
    import instruction_decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] in_word = '0, in_pc = '0;

    always #5 clk = ~clk;

    logic       a_in_ready, a_out_valid, a_mem_unsigned, a_out_illegal;
    Instruction a_out_instr;
    logic [31:0] a_out_pc;
    logic [1:0] a_mem_size, a_state;
    logic [7:0] a_illegal_count;

    logic       b_in_ready, b_out_valid, b_mem_unsigned, b_out_illegal;
    Instruction b_out_instr;
    logic [31:0] b_out_pc;
    logic [1:0] b_mem_size, b_state;
    logic [1:0] b_illegal_count;

    instruction_decode_stage u_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_word(in_word), .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_instr(a_out_instr), .out_pc(a_out_pc),
        .out_mem_size(a_mem_size), .out_mem_unsigned(a_mem_unsigned),
        .out_illegal(a_out_illegal), .state(a_state), .illegal_count(a_illegal_count)
    );

    instruction_decode_stage #(
        .XLEN(32), .DEPTH(3), .SUBWORD_MEM(1'b0), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(2)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_word(in_word), .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_instr(b_out_instr), .out_pc(b_out_pc),
        .out_mem_size(b_mem_size), .out_mem_unsigned(b_mem_unsigned),
        .out_illegal(b_out_illegal), .state(b_state), .illegal_count(b_illegal_count)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        Instruction  ins;
        logic [31:0] pc;
        logic [1:0]  size;
        logic        uns;
        logic        ill;
        logic        brk;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   st[2] = '{0, 0};
    int   ic[2] = '{0, 0};

    function automatic int dep(input int k);     return (k == 0) ? 2 : 3;   endfunction
    function automatic bit sub_mem(input int k); return (k == 0);           endfunction
    function automatic bit trap(input int k);    return (k == 0);           endfunction
    function automatic int ic_max(input int k);  return (k == 0) ? 255 : 3; endfunction
    function automatic int qsize(input int k);   return (k == 0) ? q0.size() : q1.size(); endfunction
    function automatic exp_t qhead(input int k); return (k == 0) ? q0[0] : q1[0]; endfunction
    function automatic bit exp_ready(input int k);
        return (st[k] == 0) && (qsize(k) < dep(k)) && !flush;
    endfunction

    function automatic int sext(input int v, input int bits);
        if (v >= (1 << (bits - 1))) return v - (1 << bits);
        return v;
    endfunction

    function automatic Instruction mk(input op_e op, input logic [4:0] rd, input logic [4:0] r1,
                                      input logic [4:0] r2, input int imm);
        Instruction i;
        i.op = op; i.rd = rd; i.rs1 = r1; i.rs2 = r2; i.imm = imm;
        return i;
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w, input bit sb);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rd, r1, r2;
        int ii, is, ib, iu, ij, sh;
        bit ok;
        op_e op;
        f3 = w[14:12]; f7 = w[31:25]; rd = w[11:7]; r1 = w[19:15]; r2 = w[24:20];
        ii = sext(int'(w[31:20]), 12);
        is = sext(int'({w[31:25], w[11:7]}), 12);
        ib = sext(int'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
        ij = sext(int'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21);
        iu = int'({w[31:12], 12'h000});
        sh = int'(w[24:20]);
        e = '0; e.size = 2'd2; ok = 1'b1;
        case (w[6:0])
            7'h37: e.ins = mk(I_LUI, rd, 0, 0, iu);
            7'h17: e.ins = mk(I_AUIPC, rd, 0, 0, iu);
            7'h6F: e.ins = mk(I_JAL, rd, 0, 0, ij);
            7'h67: begin ok = (f3 == 0); e.ins = mk(I_JALR, rd, r1, 0, ii); end
            7'h63: begin
                ok = f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
                case (f3)
                    3'd0: op = I_BEQ;  3'd1: op = I_BNE;  3'd4: op = I_BLT;
                    3'd5: op = I_BGE;  3'd6: op = I_BLTU; default: op = I_BGEU;
                endcase
                e.ins = mk(op, 0, r1, r2, ib);
            end
            7'h03: begin
                ok = sb ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 == 3'd2);
                e.ins = mk(I_LOAD, rd, r1, 0, ii); e.size = f3[1:0]; e.uns = f3[2];
            end
            7'h23: begin
                ok = sb ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 == 3'd2);
                e.ins = mk(I_STORE, 0, r1, r2, is); e.size = f3[1:0];
            end
            7'h13: begin
                if (f3 == 3'd1) begin
                    ok = (f7 == 7'h00); e.ins = mk(I_SLLI, rd, r1, 0, sh);
                end else if (f3 == 3'd5) begin
                    ok = f7 inside {7'h00, 7'h20};
                    e.ins = mk((f7 == 7'h20) ? I_SRAI : I_SRLI, rd, r1, 0, sh);
                end else begin
                    case (f3)
                        3'd0: op = I_ADDI; 3'd2: op = I_SLTI; 3'd3: op = I_SLTIU;
                        3'd4: op = I_XORI; 3'd6: op = I_ORI;  default: op = I_ANDI;
                    endcase
                    e.ins = mk(op, rd, r1, 0, ii);
                end
            end
            7'h33: begin
                case (f3)
                    3'd0: op = I_ADD; 3'd1: op = I_SLL; 3'd2: op = I_SLT;  3'd3: op = I_SLTU;
                    3'd4: op = I_XOR; 3'd5: op = I_SRL; 3'd6: op = I_OR;   default: op = I_AND;
                endcase
                if (f7 == 7'h20 && f3 == 3'd0) op = I_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) op = I_SRA;
                else if (f7 != 7'h00) ok = 1'b0;
                e.ins = mk(op, rd, r1, r2, 0);
            end
            7'h0F: ok = (f3 == 3'd0);
            7'h73: begin
                ok = (w == 32'h0010_0073); e.brk = ok; e.ins = mk(I_EBREAK, 0, 0, 0, 0);
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e = '0; e.size = 2'd2; e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic model_step(input int k);
        bit rdy, vld, psh, pp;
        exp_t e;
        rdy = exp_ready(k);
        vld = (qsize(k) > 0);
        psh = in_valid && rdy;
        pp  = vld && out_ready;
        if (flush) begin
            if (k == 0) q0.delete(); else q1.delete();
            st[k] = 0;
        end else begin
            if (pp) begin
                if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            if (psh) begin
                e = ref_decode(in_word, sub_mem(k));
                e.pc = in_pc;
                if (k == 0) q0.push_back(e); else q1.push_back(e);
                if (e.ill && ic[k] < ic_max(k)) ic[k]++;
                if (e.brk) st[k] = 1;
                else if (e.ill && trap(k)) st[k] = 2;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                q0.delete(); q1.delete();
                st = '{0, 0}; ic = '{0, 0};
            end else begin
                for (int k = 0; k < 2; k++) model_step(k);
            end
        end
    end

    task automatic cmp(input int k, input logic rdy, input logic vld, input logic [1:0] stt,
                       input logic [7:0] icnt, input Instruction ins, input logic [31:0] pc,
                       input logic [1:0] sz, input logic uns, input logic ill);
        exp_t h;
        string p;
        p = (k == 0) ? "A" : "B";
        check({p, " in_ready"}, 64'(rdy), 64'(exp_ready(k)));
        check({p, " out_valid"}, 64'(vld), 64'(qsize(k) > 0));
        check({p, " state"}, 64'(stt), 64'(st[k]));
        check({p, " illegal_count"}, 64'(icnt), 64'(ic[k]));
        if (qsize(k) > 0) begin
            h = qhead(k);
            check({p, " out_instr"}, 64'(ins), 64'(h.ins));
            check({p, " out_pc"}, 64'(pc), 64'(h.pc));
            check({p, " out_mem_size"}, 64'(sz), 64'(h.size));
            check({p, " out_mem_unsigned"}, 64'(uns), 64'(h.uns));
            check({p, " out_illegal"}, 64'(ill), 64'(h.ill));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                cmp(0, a_in_ready, a_out_valid, a_state, a_illegal_count, a_out_instr,
                    a_out_pc, a_mem_size, a_mem_unsigned, a_out_illegal);
                cmp(1, b_in_ready, b_out_valid, b_state, {6'b0, b_illegal_count}, b_out_instr,
                    b_out_pc, b_mem_size, b_mem_unsigned, b_out_illegal);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] w, input logic [31:0] pc);
        in_valid = 1'b1; in_word = w; in_pc = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    function automatic logic [31:0] addi_rd(input int r);
        logic [4:0] rr;
        rr = 5'(r);
        return {12'(r), 5'd0, 3'b000, rr, 7'h13};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int sel;
        w = $urandom();
        sel = $urandom_range(0, 13);
        case (sel)
            0:  w[6:0] = 7'h37;
            1:  w[6:0] = 7'h17;
            2:  w[6:0] = 7'h6F;
            3:  w[6:0] = 7'h67;
            4:  w[6:0] = 7'h63;
            5:  w[6:0] = 7'h03;
            6:  w[6:0] = 7'h23;
            7, 8: begin
                w[6:0] = (sel == 7) ? 7'h13 : 7'h33;
                case ($urandom_range(0, 3))
                    0, 1: w[31:25] = 7'h00;
                    2: w[31:25] = 7'h20;
                    default: ;
                endcase
            end
            9:  w[6:0] = 7'h0F;
            10: begin w[6:0] = 7'h0F; w[14:12] = 3'b000; end
            11: w = ($urandom_range(0, 3) == 0) ? 32'h0010_0073 : 32'h0000_0073;
            12: w[6:0] = 7'h73;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("reset in_ready", 64'(a_in_ready), 64'd1);
        check("reset out_valid", 64'(a_out_valid), 64'd0);
        check("reset state", 64'(a_state), 64'd0);
        check("reset illegal_count", 64'(a_illegal_count), 64'd0);

        // ADDI x1,x0,-10 at 0x100
        push1(32'hFF60_0093, 32'h100);
        check("addi out_valid", 64'(a_out_valid), 64'd1);
        check("addi imm", 64'(a_out_instr.imm), 64'hFFFF_FFF6);
        check("addi op", 64'(a_out_instr.op), 64'(I_ADDI));
        check("addi rd", 64'(a_out_instr.rd), 64'd1);
        check("addi pc", 64'(a_out_pc), 64'h100);
        check("addi illegal", 64'(a_out_illegal), 64'd0);
        check("addi size", 64'(a_mem_size), 64'd2);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // fill, back-pressure, then push with simultaneous pop
        push1(addi_rd(1), 32'h10);
        push1(addi_rd(2), 32'h14);
        check("full in_ready", 64'(a_in_ready), 64'd0);
        check("full head", 64'(a_out_instr.rd), 64'd1);
        out_ready = 1'b1; tick();
        check("pop head", 64'(a_out_instr.rd), 64'd2);
        push1(addi_rd(3), 32'h18);
        check("push+pop head", 64'(a_out_instr.rd), 64'd3);
        check("push+pop in_ready", 64'(a_in_ready), 64'd1);
        out_ready = 1'b0;
        push1(addi_rd(4), 32'h1C);
        check("refill in_ready", 64'(a_in_ready), 64'd0);
        check("refill head", 64'(a_out_instr.rd), 64'd3);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("order next", 64'(a_out_instr.rd), 64'd4);
        do_flush();

        // ECALL traps A, not B
        push1(32'h0000_0073, 32'h200);
        check("ecall illegal", 64'(a_out_illegal), 64'd1);
        check("ecall op", 64'(a_out_instr.op), 64'(I_NOP));
        check("ecall pc", 64'(a_out_pc), 64'h200);
        check("ecall count", 64'(a_illegal_count), 64'd1);
        check("ecall state", 64'(a_state), 64'd2);
        check("ecall in_ready", 64'(a_in_ready), 64'd0);
        check("ecall B state", 64'(b_state), 64'd0);
        do_flush();
        check("flush state", 64'(a_state), 64'd0);
        check("flush out_valid", 64'(a_out_valid), 64'd0);
        check("flush count kept", 64'(a_illegal_count), 64'd1);

        // LBU x5,4(x2)
        push1(32'h0041_4283, 32'h300);
        check("lbu size", 64'(a_mem_size), 64'd0);
        check("lbu unsigned", 64'(a_mem_unsigned), 64'd1);
        check("lbu illegal", 64'(a_out_illegal), 64'd0);
        check("lbu imm", 64'(a_out_instr.imm), 64'd4);
        check("lbu rs1", 64'(a_out_instr.rs1), 64'd2);
        check("lbu B illegal", 64'(b_out_illegal), 64'd1);
        do_flush();

        // EBREAK halts; following ADDI is refused; EBREAK drains
        push1(32'h0010_0073, 32'h400);
        push1(addi_rd(7), 32'h404);
        check("ebreak state", 64'(a_state), 64'd1);
        check("ebreak in_ready", 64'(a_in_ready), 64'd0);
        check("ebreak head", 64'(a_out_instr.op), 64'(I_EBREAK));
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("ebreak drained", 64'(a_out_valid), 64'd0);
        check("ebreak still halted", 64'(a_state), 64'd1);
        do_flush();

        // async reset mid-burst
        push1(addi_rd(8), 32'h500);
        push1(addi_rd(9), 32'h504);
        #2 reset_n = 1'b0;
        #1;
        check("async reset A out_valid", 64'(a_out_valid), 64'd0);
        check("async reset B out_valid", 64'(b_out_valid), 64'd0);
        check("async reset count", 64'(a_illegal_count), 64'd0);
        @(negedge clk); #1 reset_n = 1'b1;
        tick();
        check("post reset in_ready", 64'(a_in_ready), 64'd1);
        check("post reset out_valid", 64'(a_out_valid), 64'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_word   = rand_word();
            in_pc     = $urandom() & 32'hFFFF_FFFC;
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 11) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
